// File: rtl/rdec_pkg.sv
// Shared constants and types for the register-bank write-enable sequencer.
package rdec_pkg;

    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_INSTR = 2'd1;
    localparam logic [1:0] SRC_MICRO = 2'd2;
    localparam logic [1:0] SRC_BURST = 2'd3;

    localparam int BCAST_CODE_DEF = 31;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/rdec_seq_if.sv
// Request/strobe bundle between the control unit (master) and the sequencer (slave).
interface rdec_seq_if #(
    parameter int NUM_REGS = 19,
    parameter int SEL_W    = 5,
    parameter int BLEN_W   = 3
);
    logic                req;
    logic                ready;
    logic [1:0]          src_sel;
    logic [SEL_W-1:0]    instr_dst;
    logic [SEL_W-1:0]    micro_dst;
    logic [BLEN_W-1:0]   burst_len;
    logic [NUM_REGS-1:0] wr_en;
    logic                busy;
    logic                err;

    modport master (
        output req, src_sel, instr_dst, micro_dst, burst_len,
        input  ready, wr_en, busy, err
    );

    modport slave (
        input  req, src_sel, instr_dst, micro_dst, burst_len,
        output ready, wr_en, busy, err
    );
endinterface

// File: rtl/rdec_onehot.sv
// Combinational destination-code decoder: code -> one-hot strobe vector plus illegal flag.
// Zero latency; no flow control.
module rdec_onehot #(
    parameter int NUM_REGS   = 19,
    parameter int SEL_W      = 5,
    parameter int BCAST_CODE = 31,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic [SEL_W-1:0]    code,
    output logic [NUM_REGS-1:0] onehot,
    output logic                illegal
);
    localparam logic [SEL_W-1:0] BC = SEL_W'(BCAST_CODE);
    localparam logic [SEL_W-1:0] NR = SEL_W'(NUM_REGS);

    always_comb begin
        onehot  = '0;
        illegal = 1'b0;
        if (code == BC) begin
            onehot = '1;
        end else if (code > NR) begin
            illegal = 1'b1;
        end else begin
            // code 0 matches no bit, so it decodes to all zeros without error
            for (int i = 0; i < NUM_REGS; i++) begin
                onehot[i] = (code == (MSB_FIRST ? SEL_W'(NUM_REGS - i) : SEL_W'(i + 1)));
            end
        end
    end
endmodule

// File: rtl/rdec_seq.sv
// Register-bank write-enable sequencer: single, broadcast and burst strobes, one cycle after accept.
// ready is low while a burst is stepping; requests are held off until it returns to IDLE.
module rdec_seq
    import rdec_pkg::*;
#(
    parameter int NUM_REGS   = 19,
    parameter int SEL_W      = 5,
    parameter int BCAST_CODE = BCAST_CODE_DEF,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int BLEN_W     = 3
) (
    input  logic       Clock,
    input  logic       Reset_n,
    rdec_seq_if.slave  bus
);
    localparam int             CW   = SEL_W + 1;
    localparam logic [CW-1:0]  LAST = CW'(NUM_REGS);

    state_t              state_q, state_d;
    logic [CW-1:0]       code_q, code_d;
    logic [BLEN_W-1:0]   rem_q, rem_d;
    logic [NUM_REGS-1:0] wr_q, wr_d;
    logic                err_q, err_d;
    logic [SEL_W-1:0]    dec_code;
    logic [NUM_REGS-1:0] dec_onehot;
    logic                dec_illegal;

    rdec_onehot #(
        .NUM_REGS   (NUM_REGS),
        .SEL_W      (SEL_W),
        .BCAST_CODE (BCAST_CODE),
        .MSB_FIRST  (MSB_FIRST)
    ) u_dec (
        .code    (dec_code),
        .onehot  (dec_onehot),
        .illegal (dec_illegal)
    );

    always_comb begin
        dec_code = bus.micro_dst;
        if (state_q == BURST) begin
            dec_code = code_q[SEL_W-1:0];
        end else if (bus.src_sel == SRC_INSTR) begin
            dec_code = bus.instr_dst;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        rem_d   = rem_q;
        wr_d    = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    case (bus.src_sel)
                        SRC_INSTR, SRC_MICRO: begin
                            wr_d  = dec_onehot;
                            err_d = dec_illegal;
                        end
                        SRC_BURST: begin
                            if (bus.burst_len <= BLEN_W'(1) || bus.micro_dst == SEL_W'(BCAST_CODE)) begin
                                wr_d  = dec_onehot;
                                err_d = dec_illegal;
                            end else if (bus.micro_dst == '0 || dec_illegal) begin
                                err_d = 1'b1;
                            end else begin
                                wr_d    = dec_onehot;
                                code_d  = {1'b0, bus.micro_dst} + CW'(1);
                                rem_d   = bus.burst_len - BLEN_W'(1);
                                state_d = BURST;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            BURST: begin
                // Running past the last register ends the burst with an error instead of wrapping
                if (code_q > LAST) begin
                    err_d   = 1'b1;
                    code_d  = '0;
                    rem_d   = '0;
                    state_d = IDLE;
                end else begin
                    wr_d   = dec_onehot;
                    code_d = code_q + CW'(1);
                    rem_d  = rem_q - BLEN_W'(1);
                    if (rem_q == BLEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            rem_q   <= '0;
            wr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            rem_q   <= rem_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.busy  = (state_q == BURST);
    assign bus.wr_en = wr_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_rdec_seq.sv
// Self-checking bench for rdec_seq: directed scenarios plus randomized traffic against a strobe-list model.
module tb_rdec_seq;
    localparam int NR = 19;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rdec_seq_if #(.NUM_REGS(NR), .SEL_W(5), .BLEN_W(3)) bus ();
    rdec_seq_if #(.NUM_REGS(NR), .SEL_W(5), .BLEN_W(3)) bus0 ();

    rdec_seq #(.NUM_REGS(NR), .SEL_W(5), .BCAST_CODE(31), .MSB_FIRST(1'b1), .BLEN_W(3))
        dut (.Clock(clk), .Reset_n(rst_n), .bus(bus));
    rdec_seq #(.NUM_REGS(NR), .SEL_W(5), .BCAST_CODE(31), .MSB_FIRST(1'b0), .BLEN_W(3))
        dut0 (.Clock(clk), .Reset_n(rst_n), .bus(bus0));

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [NR-1:0] wr;
        logic          err;
    } exp_t;
    exp_t q[$];

    task automatic drive(input logic r, input logic [1:0] s, input logic [4:0] i,
                         input logic [4:0] m, input logic [2:0] l);
        bus.req = r; bus.src_sel = s; bus.instr_dst = i; bus.micro_dst = m; bus.burst_len = l;
    endtask

    // Expected strobe for code c with MSB-first bit ordering
    function automatic logic [NR-1:0] mdec(input int c);
        logic [NR-1:0] one;
        one = 1;
        if (c == 31) return '1;
        if (c < 1 || c > NR) return '0;
        return one << (NR - c);
    endfunction

    function automatic logic merr(input int c);
        return (c > NR && c != 31);
    endfunction

    task automatic push(input logic [NR-1:0] w, input logic e);
        exp_t x;
        x.wr = w; x.err = e;
        q.push_back(x);
    endtask

    // Expected per-cycle outputs for one accepted request, as a list of strobe cycles
    task automatic model_push(input int s, input int i, input int m, input int l);
        case (s)
            0: push('0, 1'b0);
            1: push(mdec(i), merr(i));
            2: push(mdec(m), merr(m));
            default: begin
                if (l <= 1 || m == 31) push(mdec(m), merr(m));
                else if (m == 0 || m > NR) push('0, 1'b1);
                else begin
                    for (int k = m; k < m + l; k++) begin
                        if (k > NR) begin
                            push('0, 1'b1);
                            break;
                        end
                        push(mdec(k), 1'b0);
                    end
                end
            end
        endcase
    endtask

    task automatic test_reset;
        drive(0, 0, 0, 0, 0);
        bus0.req = 0; bus0.src_sel = 0; bus0.instr_dst = 0; bus0.micro_dst = 0; bus0.burst_len = 0;
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if (bus.wr_en !== '0 || bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: wr_en=%h err=%b busy=%b ready=%b, want 0/0/0/1",
                     bus.wr_en, bus.err, bus.busy, bus.ready);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_single;
        logic [4:0]    codes[3];
        logic [NR-1:0] exp[3];
        codes = '{5'd1, 5'd19, 5'd31};
        exp   = '{19'h40000, 19'h00001, 19'h7FFFF};
        @(negedge clk) drive(1, 1, codes[0], 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.wr_en !== exp[k] || bus.err !== 1'b0 || bus.ready !== 1'b1) begin
                n_fail++;
                $display("FAIL single_%0d: wr_en=%h err=%b ready=%b, want %h/0/1",
                         k, bus.wr_en, bus.err, bus.ready, exp[k]);
            end
            if (k < 2) drive(1, 1, codes[k+1], 0, 0);
            else drive(0, 0, 0, 0, 0);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.wr_en !== '0) begin
            n_fail++;
            $display("FAIL single_pulse: wr_en=%h, want 0", bus.wr_en);
        end
    endtask

    task automatic test_illegal;
        @(negedge clk) drive(1, 2, 0, 20, 0);
        @(negedge clk);
        n_cmp++;
        if (bus.wr_en !== '0 || bus.err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_20: wr_en=%h err=%b, want 0/1", bus.wr_en, bus.err);
        end
        drive(1, 2, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (bus.wr_en !== '0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL code_zero: wr_en=%h err=%b, want 0/0", bus.wr_en, bus.err);
        end
        drive(1, 3, 0, 0, 3);
        @(negedge clk);
        n_cmp++;
        if (bus.wr_en !== '0 || bus.err !== 1'b1 || bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_zero: wr_en=%h err=%b ready=%b, want 0/1/1", bus.wr_en, bus.err, bus.ready);
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: err=%b, want 0", bus.err);
        end
    endtask

    task automatic test_burst;
        logic [NR-1:0] exp[3];
        logic          rdy[3];
        exp = '{19'h04000, 19'h02000, 19'h01000};
        rdy = '{1'b0, 1'b0, 1'b1};
        @(negedge clk) drive(1, 3, 0, 5, 3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.wr_en !== exp[k] || bus.err !== 1'b0 || bus.ready !== rdy[k] || bus.busy !== !rdy[k]) begin
                n_fail++;
                $display("FAIL burst_%0d: wr_en=%h err=%b ready=%b busy=%b, want %h/0/%b/%b",
                         k, bus.wr_en, bus.err, bus.ready, bus.busy, exp[k], rdy[k], !rdy[k]);
            end
            // a request offered while busy must be ignored
            if (k < 2) drive(1, 1, 1, 0, 0);
            else drive(0, 0, 0, 0, 0);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.wr_en !== '0) begin
            n_fail++;
            $display("FAIL burst_ignored_req: wr_en=%h, want 0", bus.wr_en);
        end
    endtask

    task automatic test_overrun;
        logic [NR-1:0] exp[4];
        logic          er[4];
        logic          rdy[4];
        exp = '{19'h00004, 19'h00002, 19'h00001, 19'h00000};
        er  = '{1'b0, 1'b0, 1'b0, 1'b1};
        rdy = '{1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk) drive(1, 3, 0, 17, 4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0);
            n_cmp++;
            if (bus.wr_en !== exp[k] || bus.err !== er[k] || bus.ready !== rdy[k]) begin
                n_fail++;
                $display("FAIL overrun_%0d: wr_en=%h err=%b ready=%b, want %h/%b/%b",
                         k, bus.wr_en, bus.err, bus.ready, exp[k], er[k], rdy[k]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (bus.err !== 1'b0 || bus.ready !== 1'b1 || bus.wr_en !== '0) begin
            n_fail++;
            $display("FAIL overrun_after: wr_en=%h err=%b ready=%b, want 0/0/1", bus.wr_en, bus.err, bus.ready);
        end
    endtask

    task automatic test_bcast_burst;
        @(negedge clk) drive(1, 3, 0, 31, 5);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if (bus.wr_en !== 19'h7FFFF || bus.busy !== 1'b0 || bus.ready !== 1'b1 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL bcast_burst: wr_en=%h busy=%b ready=%b err=%b, want 7ffff/0/1/0",
                     bus.wr_en, bus.busy, bus.ready, bus.err);
        end
    endtask

    task automatic test_lsb_first;
        @(negedge clk);
        bus0.req = 1; bus0.src_sel = 1; bus0.instr_dst = 1;
        @(negedge clk);
        n_cmp++;
        if (bus0.wr_en !== 19'h00001) begin
            n_fail++;
            $display("FAIL lsb_code1: wr_en=%h, want 00001", bus0.wr_en);
        end
        bus0.src_sel = 2; bus0.micro_dst = 19;
        @(negedge clk);
        bus0.req = 0;
        n_cmp++;
        if (bus0.wr_en !== 19'h40000) begin
            n_fail++;
            $display("FAIL lsb_code19: wr_en=%h, want 40000", bus0.wr_en);
        end
    endtask

    task automatic test_reset_mid_burst;
        @(negedge clk) drive(1, 3, 0, 2, 6);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if (bus.wr_en !== 19'h20000) begin
            n_fail++;
            $display("FAIL midrst_s1: wr_en=%h, want 20000", bus.wr_en);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.wr_en !== 19'h10000 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_s2: wr_en=%h busy=%b, want 10000/1", bus.wr_en, bus.busy);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.wr_en !== '0 || bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_async: wr_en=%h err=%b busy=%b ready=%b, want 0/0/0/1",
                     bus.wr_en, bus.err, bus.busy, bus.ready);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.wr_en !== '0 || bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_after_%0d: wr_en=%h ready=%b busy=%b, want 0/1/0",
                         k, bus.wr_en, bus.ready, bus.busy);
            end
        end
    endtask

    task automatic test_random;
        exp_t e;
        logic r;
        int   s, i, m, l;
        q.delete();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            e = (q.size() > 0) ? q.pop_front() : '0;
            n_cmp++;
            if (bus.wr_en !== e.wr || bus.err !== e.err) begin
                n_fail++;
                $display("FAIL rand_out c=%0d: wr_en=%h err=%b, want %h/%b", c, bus.wr_en, bus.err, e.wr, e.err);
            end
            n_cmp++;
            if (bus.ready !== (q.size() == 0) || bus.busy !== (q.size() != 0)) begin
                n_fail++;
                $display("FAIL rand_hs c=%0d: ready=%b busy=%b, want %b/%b",
                         c, bus.ready, bus.busy, q.size() == 0, q.size() != 0);
            end
            r = (c < 385) && ($urandom_range(0, 3) != 0);
            s = $urandom_range(0, 3);
            i = $urandom_range(0, 31);
            case ($urandom_range(0, 4))
                0:       m = $urandom_range(0, 31);
                1:       m = 31;
                default: m = $urandom_range(1, NR);
            endcase
            l = $urandom_range(0, 7);
            drive(r, 2'(s), 5'(i), 5'(m), 3'(l));
            if (r && q.size() == 0) model_push(s, i, m, l);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_illegal();
        test_burst();
        test_overrun();
        test_bcast_burst();
        test_lsb_first();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rdec_seq.md
Name: rdec_seq

Overview:
Parametrised register-file write-enable decoder/sequencer for the datapath register bank (general registers plus PC, TOTR, MDDR, TR and AR). It selects a destination code from the instruction field or the microcode field, decodes it to a registered one-hot write strobe, and supports broadcast. It also has a burst mode that strobes consecutive registers on successive cycles for block loads. A valid/ready handshake stalls the control unit while a burst is in progress.

Parameters:
NUM_REGS, 19, number of write-enable lines
SEL_W, 5, destination code width
BCAST_CODE, 31, code that asserts every strobe; must be > NUM_REGS and < 2**SEL_W
MSB_FIRST, 1, 1: code k drives bit NUM_REGS-k; 0: code k drives bit k-1
BLEN_W, 3, burst length field width

Ports:
Clock  in  1  system clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
req  in  1  request valid
ready  out  1  request accepted when req&&ready at a rising edge
src_sel  in  2  0 none, 1 instruction field, 2 microcode field, 3 burst from microcode field
instr_dst  in  SEL_W  destination code from instruction register
micro_dst  in  SEL_W  destination code from microcode
burst_len  in  BLEN_W  number of registers in burst
wr_en  out  NUM_REGS  registered one-hot write strobes
busy  out  1  burst in progress
err  out  1  one-cycle pulse on an illegal code

Behaviour:
- Reset (async assert, sync-safe release): wr_en=0, err=0, busy=0, state IDLE, internal counters 0. ready=1 while in reset.
- ready = (state==IDLE). busy = (state==BURST). Both are decoded from state only.
- Decode of code c:
  - c==0 -> all zeros, no error.
  - 1<=c<=NUM_REGS -> single bit per MSB_FIRST.
  - c==BCAST_CODE -> all ones.
  - Any other value -> all zeros and err=1 for that cycle.
- Latency: accept at edge T, so wr_en shows the decoded value for exactly one cycle after edge T. Without an accepted request or burst step, wr_en=0. Strobes are pulses and never hold.
- IDLE accept:
  - src 0 -> wr_en=0.
  - src 1 -> decode instr_dst.
  - src 2 -> decode micro_dst.
  - src 3 -> burst with start code s=micro_dst and length L=burst_len.
- Burst entry:
  - L==0 or L==1 -> single decode of s; stay IDLE.
  - s==BCAST_CODE -> one all-ones strobe, no burst, regardless of L.
  - s==0 or s illegal -> err pulse, wr_en=0, stay IDLE.
  - Otherwise decode s, latch next code s+1 and remaining count L-1, go to BURST.
- BURST, each edge:
  - Decode the latched code and decrement remaining.
  - Return to IDLE on the edge where remaining reaches 0.
  - req is ignored (ready=0).
  - A burst of L occupies L strobe cycles with ready low for L-1 cycles.
- Overrun: if the latched code exceeds NUM_REGS, that edge gives wr_en=0 and err=1, and the burst terminates to IDLE. The code never wraps to 0.
- Code increment is computed at SEL_W+1 bits so that overflow is detected, not wrapped.
- Reset mid-burst: all outputs clear immediately and the FSM is IDLE after release. The aborted burst is not resumed.
- err is registered, aligned with the wr_en cycle it qualifies, and cleared the next cycle unless re-raised.

Decomposition:
- Package rdec_pkg holds:
  - src_sel constants SRC_NONE=0, SRC_INSTR=1, SRC_MICRO=2, SRC_BURST=3
  - state enum IDLE/BURST
  - default BCAST_CODE
- Sub-module rdec_onehot: purely combinational code -> {onehot, illegal}, parametrised by NUM_REGS, SEL_W, BCAST_CODE, MSB_FIRST. One instance is fed by the source/burst mux.

Test Plan:
- Defaults, src=1, instr_dst=1, then 19, then 31 -> wr_en 19'h40000, 19'h00001, 19'h7FFFF on successive cycles; err=0; ready stays 1.
- src=2, micro_dst=20, then micro_dst=0 -> wr_en=0 with err=1 for one cycle; then wr_en=0 with err=0.
- src=3, micro_dst=5, burst_len=3 -> wr_en 19'h04000, 19'h02000, 19'h01000 on 3 consecutive cycles; ready low 2 cycles; busy high 2 cycles; a req during the burst is not accepted.
- src=3, micro_dst=17, burst_len=4 -> 19'h00004, 19'h00002, 19'h00001, then wr_en=0 with err=1; FSM returns to IDLE (ready=1) after the 4th cycle.
- src=3, micro_dst=31, burst_len=5 -> single 19'h7FFFF, no busy; MSB_FIRST=0 build with code 1 -> 19'h00001.
- Burst micro_dst=2, len=6, Reset_n low after the 2nd strobe -> wr_en, err, busy go 0 asynchronously; after release wr_en stays 0 and ready=1.
